// File: rtl/ecc_apb_regfile.sv
// APB register file and command sequencer in front of the ECC core.
// Holds CTRL/DATA_IN/CODEWORD_WIDTH/NOISE and launches one core operation per CTRL write.
module ecc_apb_regfile #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  output logic                       start,
  output logic [1:0]                 ctrl_mode,
  output logic [AMBA_WORD-1:0]       data_in,
  output logic [1:0]                 cw_width,
  output logic [AMBA_WORD-1:0]       noise,
  output logic                       busy,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [31:0] DwVec = DATA_WIDTH;

  state_t state_q, state_d;

  logic       mapped;
  logic       wr_commit;
  logic       rd_setup;
  logic       ctrl_ok;
  logic [1:0] reg_sel;
  logic       unused_ok;

  // APB handshake: zero wait states, no PREADY. Setup phase is PSEL & !PENABLE,
  // access phase is PSEL & PENABLE; writes commit at the access edge, reads are
  // captured at the setup edge so PRDATA is valid through the access phase.
  assign reg_sel   = PADDR[3:2];
  assign mapped    = ~|PADDR[AMBA_ADDR_WIDTH-1:4];
  assign wr_commit = PSEL & PENABLE & PWRITE & mapped & (state_q == IDLE);
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign ctrl_ok   = wr_commit & (reg_sel == 2'd0) & (PWDATA[1:0] != 2'd3);

  assign start     = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign state     = state_q;
  assign unused_ok = ^{PADDR[1:0], DwVec[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_ok) state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (operation_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Register writes; value 3 in the 2-bit fields is illegal and leaves the field as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_mode <= 2'd0;
      data_in   <= '0;
      cw_width  <= 2'd0;
      noise     <= '0;
    end else if (wr_commit) begin
      case (reg_sel)
        2'd0:    if (PWDATA[1:0] != 2'd3) ctrl_mode <= PWDATA[1:0];
        2'd1:    data_in <= PWDATA;
        2'd2:    if (PWDATA[1:0] != 2'd3) cw_width <= PWDATA[1:0];
        default: noise <= PWDATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PRDATA <= '0;
    end else if (rd_setup) begin
      if (!mapped) begin
        PRDATA <= '0;
      end else begin
        case (reg_sel)
          2'd0:    PRDATA <= {{(AMBA_WORD-3){1'b0}}, busy, ctrl_mode};
          2'd1:    PRDATA <= data_in;
          2'd2:    PRDATA <= {{(AMBA_WORD-2){1'b0}}, cw_width};
          default: PRDATA <= noise;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// Directed bench for ecc_apb_regfile: APB driver tasks, immediate-assert checks, summary.
module tb_ecc_apb_regfile;

  logic        clk;
  logic        rst;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic        PSEL;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        operation_done;
  logic        start;
  logic [1:0]  ctrl_mode;
  logic [31:0] data_in;
  logic [1:0]  cw_width;
  logic [31:0] noise;
  logic        busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  ecc_apb_regfile #(
    .DATA_WIDTH(32),
    .AMBA_ADDR_WIDTH(20),
    .AMBA_WORD(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PENABLE(PENABLE),
    .PSEL(PSEL),
    .PWRITE(PWRITE),
    .PRDATA(PRDATA),
    .operation_done(operation_done),
    .start(start),
    .ctrl_mode(ctrl_mode),
    .data_in(data_in),
    .cw_width(cw_width),
    .noise(noise),
    .busy(busy),
    .state(state)
  );

  // Clock and start-pulse counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    data = PRDATA;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    operation_done = 1'b1;
    @(posedge clk); #1;
    operation_done = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; PADDR = '0; PWDATA = '0; PENABLE = 1'b0; PSEL = 1'b0;
    PWRITE = 1'b0; operation_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    apb_read(20'h0, rd); check("rst_rd_ctrl", rd, 32'h0);
    apb_read(20'h4, rd); check("rst_rd_data", rd, 32'h0);
    apb_read(20'h8, rd); check("rst_rd_cw", rd, 32'h0);
    apb_read(20'hC, rd); check("rst_rd_noise", rd, 32'h0);

    // Configure and launch a full operation
    apb_write(20'h4, 32'hA5A5_0F0F);
    apb_write(20'h8, 32'h2);
    apb_write(20'hC, 32'h10);
    apb_write(20'h0, 32'h2);
    check("launch_start", {31'd0, start}, 32'd1);
    check("launch_busy", {31'd0, busy}, 32'd1);
    check("launch_mode", {30'd0, ctrl_mode}, 32'd2);
    check("launch_data", data_in, 32'hA5A5_0F0F);
    check("launch_cw", {30'd0, cw_width}, 32'd2);
    check("launch_noise", noise, 32'h10);
    @(posedge clk); #1;
    check("pulse_end_start", {31'd0, start}, 32'd0);
    check("pulse_end_busy", {31'd0, busy}, 32'd1);
    apb_read(20'h0, rd); check("busy_rd_ctrl", rd, 32'h6);

    // Writes while busy are dropped
    apb_write(20'h4, 32'hFFFF_FFFF);
    apb_write(20'h0, 32'h0);
    check("locked_data", data_in, 32'hA5A5_0F0F);
    check("locked_mode", {30'd0, ctrl_mode}, 32'd2);
    check("locked_starts", start_cnt, 32'd1);
    pulse_done();
    check("done_busy", {31'd0, busy}, 32'd0);
    apb_read(20'h0, rd); check("done_rd_ctrl", rd, 32'h2);

    // Illegal values rejected in IDLE
    apb_write(20'h0, 32'h3);
    check("bad_ctrl_start", {31'd0, start}, 32'd0);
    check("bad_ctrl_busy", {31'd0, busy}, 32'd0);
    apb_write(20'h8, 32'h3);
    check("bad_cw_keep", {30'd0, cw_width}, 32'd2);
    apb_read(20'h0, rd); check("bad_rd_ctrl", rd, 32'h2);
    apb_read(20'h8, rd); check("bad_rd_cw", rd, 32'h2);
    check("bad_starts", start_cnt, 32'd1);

    // Unmapped addresses
    apb_read(20'h10, rd); check("unmap_rd_10", rd, 32'h0);
    apb_read(20'hF_FFFC, rd); check("unmap_rd_fffc", rd, 32'h0);
    apb_write(20'h10, 32'h1234);
    check("unmap_wr_mode", {30'd0, ctrl_mode}, 32'd2);
    check("unmap_wr_data", data_in, 32'hA5A5_0F0F);
    check("unmap_wr_noise", noise, 32'h10);
    check("unmap_wr_starts", start_cnt, 32'd1);

    // Back-to-back read-after-write; PADDR[1:0] ignored
    apb_write(20'hF, 32'h0000_0055);
    apb_read(20'hC, rd); check("raw_noise", rd, 32'h55);

    // Launch, then reset mid-operation
    apb_write(20'h0, 32'h1);
    check("op2_start", {31'd0, start}, 32'd1);
    apb_read(20'h0, rd); check("op2_rd_ctrl", rd, 32'h5);
    check("op2_starts", start_cnt, 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_start", {31'd0, start}, 32'd0);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    check("mid_rst_mode", {30'd0, ctrl_mode}, 32'd0);
    check("mid_rst_data", data_in, 32'h0);
    check("mid_rst_cw", {30'd0, cw_width}, 32'd0);
    check("mid_rst_noise", noise, 32'h0);
    check("mid_rst_prdata", PRDATA, 32'h0);
    pulse_done();
    repeat (2) @(posedge clk);
    #1;
    check("late_done_busy", {31'd0, busy}, 32'd0);
    check("late_done_state", {30'd0, state}, 32'd0);
    check("late_done_starts", start_cnt, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_apb_regfile.md
# ecc_apb_regfile

APB-slave register file and command sequencer sitting directly upstream of the ECC encoder/decoder core. It decodes zero-wait-state APB transfers into four configuration registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) and supplies PRDATA readback. A valid CTRL write launches one core operation with a single-cycle start pulse. Further writes are locked out until the core returns operation_done.

## Interface
- DATA_WIDTH, 32, core data path width; not used internally, carried for consistency.
- AMBA_ADDR_WIDTH, 20, APB address width.
- AMBA_WORD, 32, APB data and register width.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- PADDR  in  AMBA_ADDR_WIDTH  APB address.
- PWDATA  in  AMBA_WORD  APB write data.
- PENABLE  in  1  APB access phase.
- PSEL  in  1  APB select.
- PWRITE  in  1  1 = write, 0 = read.
- PRDATA  out  AMBA_WORD  registered read data.
- operation_done  in  1  core completion pulse.
- start  out  1  one-cycle operation launch to the core.
- ctrl_mode  out  2  0 = encode, 1 = decode, 2 = full (encode, noise, decode).
- data_in  out  AMBA_WORD  DATA_IN register.
- cw_width  out  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit codeword.
- noise  out  AMBA_WORD  NOISE register.
- busy  out  1  high from the start pulse until operation_done is accepted.

## Operation
- Address map uses PADDR[3:2]; PADDR[1:0] are ignored.
  - 0x00 CTRL
  - 0x04 DATA_IN
  - 0x08 CODEWORD_WIDTH
  - 0x0C NOISE
- Any set bit in PADDR[AMBA_ADDR_WIDTH-1:4] is unmapped: writes are dropped and reads return 0.
- Write commit: PSEL & PENABLE & PWRITE, only when the FSM is in IDLE. In START or BUSY every write is dropped, registers are unchanged and no error is raised.
- Per-register write rules:
  - CTRL stores PWDATA[1:0]. A value of 3 is rejected: the register is unchanged and no start is issued.
  - CODEWORD_WIDTH stores PWDATA[1:0]. A value of 3 is rejected and the prior value is kept.
  - DATA_IN and NOISE store the full word.
- Read data by register:
  - CTRL: {zeros, busy, ctrl_mode}, with busy in bit 2.
  - CODEWORD_WIDTH: zero-extended cw_width.
  - DATA_IN and NOISE: full register contents.
- FSM states:
  - IDLE: an accepted CTRL write with value 0..2 moves the FSM to START.
  - START: start = 1 for exactly this cycle; the next state is always BUSY.
  - BUSY: operation_done = 1 returns the FSM to IDLE.
- operation_done is honoured only in BUSY and is ignored in IDLE and START.
- busy = 1 in START and BUSY.
- Register outputs update the cycle after commit. ctrl_mode, data_in, cw_width and noise are stable whenever start is high.
- Reset, including mid-operation, returns everything to 0 on the next edge: all registers, PRDATA, start and busy, with the FSM in IDLE. An in-flight core operation is abandoned, and an operation_done arriving later is ignored.

## Timing
- Zero wait states; no PREADY.
- PRDATA is loaded at the setup-phase edge (PSEL & !PENABLE & !PWRITE), so it is valid throughout the access phase.
- PRDATA holds its value until the next read setup.
- Reads are served in every FSM state.
- Read-after-write to the same register in back-to-back transfers returns the new value.
- CTRL write access phase at edge N: start is high during cycle N+1 and busy goes high at N+1.
- operation_done sampled in BUSY at edge M: busy is low from M+1, and a write can be accepted at the access edge M+1.
- Simultaneous operation_done and write in the same BUSY cycle: the write is dropped.

## Test plan
- Reset, then read all four addresses: each returns 0x00000000; start = 0, busy = 0.
- Write DATA_IN = 0xA5A5_0F0F, CODEWORD_WIDTH = 2, NOISE = 0x0000_0010, then CTRL = 2: one start pulse; ctrl_mode = 2, data_in = 0xA5A50F0F, cw_width = 2, noise = 0x10; CTRL readback = 0x6.
- While busy, write DATA_IN = 0xFFFF_FFFF and CTRL = 0: no change and no second start. Pulse operation_done: busy drops the next cycle and CTRL readback = 0x2.
- Write CTRL = 3 and CODEWORD_WIDTH = 3 in IDLE: no start; cw_width keeps its prior value; reads of 0x0 and 0x8 are unchanged.
- Read 0x10 and 0xF_FFFC; write 0x10 = 0x1234: both reads return 0; no register changes.
- Assert rst in BUSY, then pulse operation_done after reset: all outputs are 0, the FSM stays in IDLE and no start fires.
